// File: rtl/debug_responder.sv
// debug_responder
// ---------------
// Host back door into the RISC-V core over a valid/ready byte channel.
// The host sends an opcode byte and its argument bytes (multi-byte fields
// MSB first). The responder executes the command and returns 1 or 4
// response bytes. Commands can halt or resume the core, write instruction
// memory, read a register or the PC, and pulse a core reset.
//
// Ports
//   clk            system clock
//   reset          synchronous, active-low reset
//   rx_data/valid  command/argument byte from the host
//   rx_ready       responder can accept a byte (IDLE/ARGS only)
//   tx_data/valid  response byte to the host
//   tx_ready       host accepts the response byte
//   cpu_halt       freezes the core while high
//   cpu_reset_req  one-cycle core reset pulse
//   imem_we        instruction-memory write strobe (qualifies addr/wdata)
//   imem_addr      instruction-memory word address
//   imem_wdata     instruction-memory write data
//   rf_raddr       debug register-file read index
//   rf_rdata       combinational register read data
//   pc_in          current core PC
//
// IMEM_ADDR_W must be in the range 9..16; the address field on the wire is
// 16 bits and only its low IMEM_ADDR_W bits are kept.
module debug_responder #(
    parameter int IMEM_ADDR_W = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   cpu_halt,
    output logic                   cpu_reset_req,
    output logic                   imem_we,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    output logic [31:0]            imem_wdata,
    output logic [4:0]             rf_raddr,
    input  logic [31:0]            rf_rdata,
    input  logic [31:0]            pc_in
);

    localparam logic [7:0] OP_HALT       = 8'h01;
    localparam logic [7:0] OP_RESUME     = 8'h02;
    localparam logic [7:0] OP_WRITE_IMEM = 8'h03;
    localparam logic [7:0] OP_READ_REG   = 8'h04;
    localparam logic [7:0] OP_READ_PC    = 8'h05;
    localparam logic [7:0] OP_RESET_CPU  = 8'h06;
    localparam logic [7:0] RSP_ACK       = 8'hA5;
    localparam logic [7:0] RSP_ERR       = 8'hEE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARGS = 2'd1,
        ST_EXEC = 2'd2,
        ST_SEND = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic                   r_rx_ready;
    logic [7:0]             r_tx_data;
    logic                   r_tx_valid;
    logic                   r_cpu_halt;
    logic                   r_cpu_reset_req;
    logic                   r_imem_we;
    logic [IMEM_ADDR_W-1:0] r_imem_addr;
    logic [31:0]            r_imem_wdata;
    logic [4:0]             r_rf_raddr;

    logic [7:0]             r_opcode;
    logic [2:0]             r_args_left;
    logic [IMEM_ADDR_W-1:0] r_addr_sh;
    logic [23:0]            r_data_sh;
    logic [23:0]            r_resp_sh;
    logic [2:0]             r_bytes_left;

    logic                   w_rx_fire;
    logic                   w_tx_fire;
    logic [7:0]             w_cmd_op;
    logic                   w_cmd_done;
    logic [31:0]            w_resp;
    logic [2:0]             w_resp_len;
    logic                   w_halt_next;

    // Number of argument bytes that follow each opcode.
    function automatic logic [2:0] arg_count(input logic [7:0] op);
        case (op)
            OP_WRITE_IMEM: arg_count = 3'd6;
            OP_READ_REG:   arg_count = 3'd1;
            default:       arg_count = 3'd0;
        endcase
    endfunction

    assign w_rx_fire = rx_valid && r_rx_ready;
    assign w_tx_fire = r_tx_valid && tx_ready;
    // In IDLE the opcode is still on the bus; afterwards it is held in r_opcode.
    assign w_cmd_op  = (r_state == ST_IDLE) ? rx_data : r_opcode;
    // The last byte of a command (opcode alone, or its final argument) is accepted.
    assign w_cmd_done = w_rx_fire &&
                        (((r_state == ST_IDLE) && (arg_count(rx_data) == 3'd0)) ||
                         ((r_state == ST_ARGS) && (r_args_left == 3'd1)));

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rx_fire) begin
                    if (arg_count(rx_data) == 3'd0) begin
                        w_next_state = ST_EXEC;
                    end else begin
                        w_next_state = ST_ARGS;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ARGS: begin
                if (w_rx_fire && (r_args_left == 3'd1)) begin
                    w_next_state = ST_EXEC;
                end else begin
                    w_next_state = ST_ARGS;
                end
            end
            ST_EXEC: begin
                w_next_state = ST_SEND;
            end
            ST_SEND: begin
                if (w_tx_fire && (r_bytes_left == 3'd1)) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_SEND;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Response word and halt update computed during EXEC; single-byte
    // responses sit in the top byte so the shifter always sends MSB first.
    always_comb begin
        w_resp      = {RSP_ERR, 24'h000000};
        w_resp_len  = 3'd1;
        w_halt_next = r_cpu_halt;
        case (r_opcode)
            OP_HALT: begin
                w_resp      = {RSP_ACK, 24'h000000};
                w_halt_next = 1'b1;
            end
            OP_RESUME: begin
                w_resp      = {RSP_ACK, 24'h000000};
                w_halt_next = 1'b0;
            end
            OP_WRITE_IMEM: begin
                if (r_cpu_halt) begin
                    w_resp = {RSP_ACK, 24'h000000};
                end else begin
                    w_resp = {RSP_ERR, 24'h000000};
                end
            end
            OP_READ_REG: begin
                if (r_rf_raddr == 5'd0) begin
                    w_resp = 32'h0000_0000;
                end else begin
                    w_resp = rf_rdata;
                end
                w_resp_len = 3'd4;
            end
            OP_READ_PC: begin
                w_resp     = pc_in;
                w_resp_len = 3'd4;
            end
            OP_RESET_CPU: begin
                w_resp = {RSP_ACK, 24'h000000};
            end
            default: begin
                w_resp = {RSP_ERR, 24'h000000};
            end
        endcase
    end

    // Argument capture, command side effects and response shifting.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rx_ready      <= 1'b0;
            r_tx_valid      <= 1'b0;
            r_tx_data       <= 8'h00;
            r_cpu_halt      <= 1'b0;
            r_cpu_reset_req <= 1'b0;
            r_imem_we       <= 1'b0;
            r_imem_addr     <= '0;
            r_imem_wdata    <= 32'h0000_0000;
            r_rf_raddr      <= 5'd0;
            r_opcode        <= 8'h00;
            r_args_left     <= 3'd0;
            r_addr_sh       <= '0;
            r_data_sh       <= 24'h000000;
            r_resp_sh       <= 24'h000000;
            r_bytes_left    <= 3'd0;
        end else begin
            r_rx_ready      <= (w_next_state == ST_IDLE) || (w_next_state == ST_ARGS);
            r_tx_valid      <= (w_next_state == ST_SEND);
            r_imem_we       <= 1'b0;
            r_cpu_reset_req <= 1'b0;

            if (w_rx_fire && (r_state == ST_IDLE)) begin
                r_opcode    <= rx_data;
                r_args_left <= arg_count(rx_data);
            end else if (w_rx_fire && (r_state == ST_ARGS)) begin
                r_args_left <= r_args_left - 3'd1;
                // Remaining count 6 and 5 are the two address bytes.
                if (r_args_left >= 3'd5) begin
                    r_addr_sh <= {r_addr_sh[IMEM_ADDR_W-9:0], rx_data};
                end else begin
                    r_data_sh <= {r_data_sh[15:0], rx_data};
                end
            end else begin
                r_args_left <= r_args_left;
            end

            // Side effects that must be visible during the EXEC cycle.
            if (w_cmd_done) begin
                case (w_cmd_op)
                    OP_WRITE_IMEM: begin
                        if (r_cpu_halt) begin
                            r_imem_we    <= 1'b1;
                            r_imem_addr  <= r_addr_sh;
                            r_imem_wdata <= {r_data_sh, rx_data};
                        end else begin
                            r_imem_we    <= 1'b0;
                        end
                    end
                    OP_READ_REG: begin
                        r_rf_raddr <= rx_data[4:0];
                    end
                    OP_RESET_CPU: begin
                        r_cpu_reset_req <= 1'b1;
                    end
                    default: begin
                        r_imem_we <= 1'b0;
                    end
                endcase
            end else begin
                r_imem_we <= 1'b0;
            end

            if (r_state == ST_EXEC) begin
                r_cpu_halt   <= w_halt_next;
                r_tx_data    <= w_resp[31:24];
                r_resp_sh    <= w_resp[23:0];
                r_bytes_left <= w_resp_len;
            end else if ((r_state == ST_SEND) && w_tx_fire) begin
                r_tx_data    <= r_resp_sh[23:16];
                r_resp_sh    <= {r_resp_sh[15:0], 8'h00};
                r_bytes_left <= r_bytes_left - 3'd1;
            end else begin
                r_bytes_left <= r_bytes_left;
            end
        end
    end

    assign rx_ready      = r_rx_ready;
    assign tx_data       = r_tx_data;
    assign tx_valid      = r_tx_valid;
    assign cpu_halt      = r_cpu_halt;
    assign cpu_reset_req = r_cpu_reset_req;
    assign imem_we       = r_imem_we;
    assign imem_addr     = r_imem_addr;
    assign imem_wdata    = r_imem_wdata;
    assign rf_raddr      = r_rf_raddr;

endmodule

// File: tb/tb_debug_responder.sv
// Self-checking bench for debug_responder. A behavioural model (halt flag,
// register array, expected write list, expected reset-pulse count) predicts
// every response byte and side effect from the command semantics.
module tb_debug_responder;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          cpu_halt;
    logic          cpu_reset_req;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [4:0]    rf_raddr;
    logic [31:0]   rf_rdata;
    logic [31:0]   pc_in;

    logic [31:0]   regs [32];
    assign rf_rdata = regs[rf_raddr];

    int n_cmp = 0;
    int n_err = 0;

    // model state
    logic          halted_m;
    logic [41:0]   exp_wr [$];
    int            exp_rst;
    // observed side effects
    logic [41:0]   seen_wr [$];
    int            rst_pulses = 0;
    int            rst_high = 0;
    logic          prev_rr = 1'b0;

    always #5 clk = ~clk;

    debug_responder #(.IMEM_ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .cpu_halt(cpu_halt), .cpu_reset_req(cpu_reset_req),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .pc_in(pc_in)
    );

    // side-effect monitor
    always @(posedge clk) begin
        if (reset === 1'b1 && imem_we === 1'b1) seen_wr.push_back({imem_addr, imem_wdata});
        if (reset === 1'b1 && cpu_reset_req === 1'b1) begin
            rst_high <= rst_high + 1;
            if (prev_rr !== 1'b1) rst_pulses <= rst_pulses + 1;
        end
        prev_rr <= cpu_reset_req;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        rx_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        rx_data = b; rx_valid = 1'b1; t = 0;
        while (rx_ready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        n_cmp++;
        if (rx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rx_timeout: rx_ready=%b required 1 for byte %02h", rx_ready, b);
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic recv_resp(input logic [7:0] e [4], input int n, input bit stall);
        int t;
        logic [7:0] got;
        tx_ready = stall ? 1'b0 : 1'b1;
        for (int i = 0; i < n; i++) begin
            t = 0;
            while (tx_valid !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
            n_cmp++;
            if (tx_valid !== 1'b1) begin
                n_err++;
                $display("FAIL tx_timeout: tx_valid=%b required 1 (byte %0d)", tx_valid, i);
                tx_ready = 1'b0;
                return;
            end
            if (!stall && i > 0) begin
                n_cmp++;
                if (t != 0) begin
                    n_err++;
                    $display("FAIL b2b_gap: byte %0d waited %0d cycles, required 0", i, t);
                end
            end
            got = tx_data;
            if (stall) begin
                repeat (2) begin
                    @(posedge clk); #1;
                    n_cmp++;
                    if (tx_valid !== 1'b1 || tx_data !== got) begin
                        n_err++;
                        $display("FAIL stall_hold: valid=%b data=%02h required 1/%02h", tx_valid, tx_data, got);
                    end
                end
                tx_ready = 1'b1;
            end
            n_cmp++;
            if (got !== e[i]) begin
                n_err++;
                $display("FAIL resp_byte%0d: got %02h required %02h", i, got, e[i]);
            end
            @(posedge clk); #1;
            if (stall) tx_ready = 1'b0;
        end
        tx_ready = 1'b0;
        n_cmp++;
        if (rx_ready !== 1'b1 || tx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL idle_return: rx_ready=%b tx_valid=%b required 1/0", rx_ready, tx_valid);
        end
    endtask

    task automatic run_cmd(input logic [7:0] op, input logic [7:0] a [6], input bit stall);
        logic [7:0]  e [4];
        int          ne, na;
        logic [15:0] a16;
        logic [31:0] v;
        na = (op == 8'h03) ? 6 : ((op == 8'h04) ? 1 : 0);
        ne = 1;
        e[0] = 8'hEE; e[1] = 8'h00; e[2] = 8'h00; e[3] = 8'h00;
        v = 32'h0;
        case (op)
            8'h01: begin halted_m = 1'b1; e[0] = 8'hA5; end
            8'h02: begin halted_m = 1'b0; e[0] = 8'hA5; end
            8'h03: begin
                if (halted_m) begin
                    a16 = {a[0], a[1]};
                    exp_wr.push_back({a16[AW-1:0], a[2], a[3], a[4], a[5]});
                    e[0] = 8'hA5;
                end else begin
                    e[0] = 8'hEE;
                end
            end
            8'h04: begin
                v = (a[0] % 32 == 0) ? 32'h0 : regs[a[0] % 32];
                ne = 4;
            end
            8'h05: begin v = pc_in; ne = 4; end
            8'h06: begin exp_rst++; e[0] = 8'hA5; end
            default: e[0] = 8'hEE;
        endcase
        if (ne == 4) begin
            e[0] = v[31:24]; e[1] = v[23:16]; e[2] = v[15:8]; e[3] = v[7:0];
        end
        send_byte(op);
        for (int i = 0; i < na; i++) send_byte(a[i]);
        recv_resp(e, ne, stall);
        n_cmp++;
        if (cpu_halt !== halted_m) begin
            n_err++;
            $display("FAIL halt_state: op %02h cpu_halt=%b required %b", op, cpu_halt, halted_m);
        end
        n_cmp++;
        if (seen_wr.size() != exp_wr.size()) begin
            n_err++;
            $display("FAIL imem_we_count: op %02h got %0d writes required %0d", op, seen_wr.size(), exp_wr.size());
        end else if (seen_wr.size() > 0 && seen_wr[$] !== exp_wr[$]) begin
            n_err++;
            $display("FAIL imem_write: got %011h required %011h", seen_wr[$], exp_wr[$]);
        end
        n_cmp++;
        if (rst_pulses != exp_rst || rst_high != exp_rst) begin
            n_err++;
            $display("FAIL reset_pulse: pulses=%0d high_cycles=%0d required %0d", rst_pulses, rst_high, exp_rst);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        n_cmp++;
        if (rx_ready !== 1'b0 || tx_valid !== 1'b0 || cpu_halt !== 1'b0 ||
            cpu_reset_req !== 1'b0 || imem_we !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: rx_ready=%b tx_valid=%b halt=%b rreq=%b we=%b required all 0",
                     rx_ready, tx_valid, cpu_halt, cpu_reset_req, imem_we);
        end
        n_cmp++;
        if (imem_addr !== '0 || imem_wdata !== 32'h0 || rf_raddr !== 5'd0 || tx_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_data: addr=%h wdata=%h raddr=%h tx_data=%h required 0",
                     imem_addr, imem_wdata, rf_raddr, tx_data);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (rx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: rx_ready=%b required 1", rx_ready);
        end
        halted_m = 1'b0;
    endtask

    task automatic test_halt;
        logic [7:0] a [6] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_byte(8'h01);
        n_cmp++;
        if (cpu_halt !== 1'b0 || rx_ready !== 1'b0 || tx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL halt_exec: halt=%b rx_ready=%b tx_valid=%b required 0/0/0", cpu_halt, rx_ready, tx_valid);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (cpu_halt !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            n_err++;
            $display("FAIL halt_ack: halt=%b valid=%b data=%02h required 1/1/a5", cpu_halt, tx_valid, tx_data);
        end
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        n_cmp++;
        if (rx_ready !== 1'b1 || tx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL halt_return: rx_ready=%b tx_valid=%b required 1/0", rx_ready, tx_valid);
        end
        halted_m = 1'b1;
        run_cmd(8'h01, a, 1'b0);
    endtask

    task automatic test_write_imem;
        logic [7:0] a [6] = '{8'h00, 8'h04, 8'h00, 8'h50, 8'h00, 8'h93};
        run_cmd(8'h03, a, 1'b0);
        n_cmp++;
        if (imem_addr !== 10'd4 || imem_wdata !== 32'h0050_0093) begin
            n_err++;
            $display("FAIL write_vec: addr=%0d wdata=%08h required 4/00500093", imem_addr, imem_wdata);
        end
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 6; j++) a[j] = 8'($urandom);
            run_cmd(8'h03, a, 1'($urandom));
        end
    endtask

    task automatic test_write_running;
        logic [7:0] a [6] = '{8'h01, 8'h23, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
        run_cmd(8'h02, a, 1'b0);
        run_cmd(8'h02, a, 1'b0);
        run_cmd(8'h03, a, 1'b0);
    endtask

    task automatic test_read_reg;
        logic [7:0] a [6] = '{8'h25, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        regs[5] = 32'hDEAD_BEEF;
        run_cmd(8'h04, a, 1'b1);
        n_cmp++;
        if (rf_raddr !== 5'd5) begin
            n_err++;
            $display("FAIL rf_raddr: got %0d required 5", rf_raddr);
        end
        a[0] = 8'h00;
        run_cmd(8'h04, a, 1'b0);
        for (int k = 0; k < 5; k++) begin
            a[0] = 8'($urandom);
            run_cmd(8'h04, a, 1'($urandom));
        end
    endtask

    task automatic test_misc;
        logic [7:0] a [6] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        pc_in = 32'h0000_0010;
        run_cmd(8'h05, a, 1'b0);
        run_cmd(8'h7F, a, 1'b0);
        run_cmd(8'h00, a, 1'b0);
        send_byte(8'h06);
        n_cmp++;
        if (cpu_reset_req !== 1'b1) begin
            n_err++;
            $display("FAIL rreq_exec: cpu_reset_req=%b required 1", cpu_reset_req);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (cpu_reset_req !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            n_err++;
            $display("FAIL rreq_after: rreq=%b valid=%b data=%02h required 0/1/a5", cpu_reset_req, tx_valid, tx_data);
        end
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        exp_rst++;
        run_cmd(8'h06, a, 1'b1);
    endtask

    task automatic test_back_to_back;
        logic [7:0] a [6];
        logic [7:0] op;
        for (int k = 0; k < 40; k++) begin
            op = 8'($urandom_range(1, 7));
            if (op == 8'h07) op = 8'($urandom_range(7, 255));
            for (int j = 0; j < 6; j++) a[j] = 8'($urandom);
            pc_in = $urandom;
            run_cmd(op, a, 1'($urandom));
        end
    endtask

    task automatic test_mid_reset;
        logic [7:0] a [6] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        int nwr;
        run_cmd(8'h01, a, 1'b0);
        nwr = seen_wr.size();
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h07);
        reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        n_cmp++;
        if (cpu_halt !== 1'b0 || rx_ready !== 1'b0 || tx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_state: halt=%b rx_ready=%b tx_valid=%b required 0/0/0", cpu_halt, rx_ready, tx_valid);
        end
        reset = 1'b1;
        halted_m = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (seen_wr.size() != nwr || rx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_nowrite: writes=%0d rx_ready=%b required %0d/1", seen_wr.size(), rx_ready, nwr);
        end
        run_cmd(8'h01, a, 1'b0);
        run_cmd(8'h02, a, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = $urandom | 32'h1;
        exp_rst = 0;
        halted_m = 1'b0;
        pc_in = 32'h0;
        tx_ready = 1'b0;
        test_reset();
        test_halt();
        test_write_imem();
        test_write_running();
        test_read_reg();
        test_misc();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
